// File: rtl/dff_pkg.sv
// Shared definitions for the dff_shift_reg register bank: mode encoding
// and the next-state function that drives every bit flip-flop.
package dff_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_RSVD  = 3'b111;

  // Widest register the bank supports; narrower banks zero-extend into this.
  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] word_t;

  // True for the four modes that move data and advance the shift counter.
  function automatic logic is_shift(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) ||
           (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

  // Next register value for a bank of 'width' bits held in the low bits of
  // a word. Bits at and above 'width' are always returned as zero.
  function automatic word_t next_q(input logic [2:0] mode,
                                   input word_t      q,
                                   input word_t      d,
                                   input logic       sin_l,
                                   input logic       sin_r,
                                   input int         width);
    word_t mask;
    word_t top;
    word_t r;
    mask = (width >= MAX_W) ? '1 : ((word_t'(1) << width) - word_t'(1));
    top  = word_t'(1) << (width - 1);
    case (mode)
      MODE_LOAD:  r = d;
      MODE_SHL:   r = (q << 1) | word_t'(sin_r);
      MODE_SHR:   r = (q >> 1) | (sin_l ? top : '0);
      MODE_ROL:   r = (q << 1) | word_t'(((q & top) != '0) ? 1'b1 : 1'b0);
      MODE_ROR:   r = (q >> 1) | (q[0] ? top : '0);
      MODE_CLEAR: r = '0;
      default:    r = q;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/dff_bit_r.sv
// Single-bit D flip-flop with asynchronous active-low reset to a
// per-instance reset value.
module dff_bit_r (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  input  logic i_rst_val,
  output logic o_q
);

  logic r_q;

  // Capture d on each rising edge; reset loads the supplied reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= i_rst_val;
    else        r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/dff_shift_reg.sv
// WIDTH-bit register bank built from per-bit flip-flops, with parallel
// load, shift/rotate in both directions, serial I/O at both ends and a
// saturating shift counter.
module dff_shift_reg
  import dff_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  word_t            w_next_full;
  logic [CW-1:0]    r_cnt;

  assign w_next_full = next_q(mode, word_t'(w_q), word_t'(d), sin_l, sin_r, WIDTH);
  assign w_next      = w_next_full[WIDTH-1:0];

  // Bits above WIDTH are always zero from next_q and are intentionally dropped.
  if (WIDTH < MAX_W) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = ^w_next_full[MAX_W-1:WIDTH];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit_r u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_d       (w_next[i]),
      .i_rst_val (RESET_VAL[i]),
      .o_q       (w_q[i])
    );
  end

  // Count shifts/rotates since the last LOAD/CLEAR/reset, saturating at WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((mode == MODE_LOAD) || (mode == MODE_CLEAR)) begin
      r_cnt <= '0;
    end else if (is_shift(mode) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign q         = w_q;
  assign sout_l    = w_q[WIDTH-1];
  assign sout_r    = w_q[0];
  assign shift_cnt = r_cnt;
  assign done      = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_dff_shift_reg.sv
// Self-checking bench for dff_shift_reg (WIDTH=8, RESET_VAL=8'hA5):
// directed scenarios followed by randomized traffic against a reference model.
module tb_dff_shift_reg;

  localparam int         W     = 8;
  localparam int         CW    = 4;
  localparam logic [7:0] RVAL  = 8'hA5;
  localparam int         MODV  = 256;

  logic          clk;
  logic          rst_n;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sin_l;
  logic          sin_r;
  logic [W-1:0]  q;
  logic          sout_l;
  logic          sout_r;
  logic [CW-1:0] shift_cnt;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: plain integers.
  int m_q;
  int m_cnt;

  dff_shift_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .d         (d),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q         (q),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: arithmetic on the integer register value.
  task automatic model_apply(input int md, input int dv, input int sl, input int sr);
    int bump;
    bump = (m_cnt + 1 > W) ? W : m_cnt + 1;
    case (md)
      1: begin m_q = dv;                               m_cnt = 0;    end
      2: begin m_q = (m_q * 2 + sr) % MODV;            m_cnt = bump; end
      3: begin m_q = m_q / 2 + sl * (MODV / 2);        m_cnt = bump; end
      4: begin m_q = (m_q * 2) % MODV + m_q / (MODV / 2); m_cnt = bump; end
      5: begin m_q = m_q / 2 + (m_q % 2) * (MODV / 2); m_cnt = bump; end
      6: begin m_q = 0;                                m_cnt = 0;    end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_q   = int'(RVAL);
    m_cnt = 0;
  endtask

  // Drive one operation, clock it, and advance the model; outputs are read #1 later.
  task automatic step(input logic [2:0] md, input logic [7:0] dv, input logic sl, input logic sr);
    mode  = md;
    d     = dv;
    sin_l = sl;
    sin_r = sr;
    @(posedge clk);
    #1;
    model_apply(int'(md), int'(dv), int'(sl), int'(sr));
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    mode = 3'b110; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_apply(6, 0, 0, 0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (q !== 8'hA5) $display("FAIL reset_q: got %h want a5", q); else n_pass++;
    n_checks++;
    if (shift_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", shift_cnt); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++;
    if ({sout_l, sout_r} !== 2'b11) $display("FAIL reset_sout: got %b want 11", {sout_l, sout_r}); else n_pass++;
    mode = 3'b001; d = 8'h3C;
    @(posedge clk); #1;
    n_checks++;
    if (q !== 8'hA5) $display("FAIL reset_hold_q: got %h want a5", q); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_shl();
    logic [7:0] exp_q [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
    step(3'b001, 8'h81, 1'b0, 1'b0);
    n_checks++;
    if (shift_cnt !== 4'd0) $display("FAIL shl_load_cnt: got %0d want 0", shift_cnt); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      step(3'b010, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (q !== exp_q[k]) $display("FAIL shl_q[%0d]: got %h want %h", k, q, exp_q[k]); else n_pass++;
      n_checks++;
      if (shift_cnt !== 4'(k + 1)) $display("FAIL shl_cnt[%0d]: got %0d want %0d", k, shift_cnt, k + 1); else n_pass++;
      n_checks++;
      if (done !== (k == 7)) $display("FAIL shl_done[%0d]: got %b want %b", k, done, (k == 7)); else n_pass++;
    end
    step(3'b010, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (shift_cnt !== 4'd8) $display("FAIL shl_sat_cnt: got %0d want 8", shift_cnt); else n_pass++;
    n_checks++;
    if (q !== 8'h01) $display("FAIL shl_sat_q: got %h want 01", q); else n_pass++;
    n_checks++;
    if (done !== 1'b1) $display("FAIL shl_sat_done: got %b want 1", done); else n_pass++;
  endtask

  task automatic test_ror();
    logic [7:0] exp_q [8] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
    step(3'b001, 8'h81, 1'b0, 1'b0);
    n_checks++;
    if (done !== 1'b0) $display("FAIL ror_load_done: got %b want 0", done); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      step(3'b101, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (q !== exp_q[k]) $display("FAIL ror_q[%0d]: got %h want %h", k, q, exp_q[k]); else n_pass++;
      n_checks++;
      if (sout_r !== exp_q[k][0]) $display("FAIL ror_sout_r[%0d]: got %b want %b", k, sout_r, exp_q[k][0]); else n_pass++;
      n_checks++;
      if (sout_l !== exp_q[k][7]) $display("FAIL ror_sout_l[%0d]: got %b want %b", k, sout_l, exp_q[k][7]); else n_pass++;
    end
    n_checks++;
    if (done !== 1'b1) $display("FAIL ror_done: got %b want 1", done); else n_pass++;
  endtask

  task automatic test_shr_hold();
    logic [7:0] exp_q [3] = '{8'h80, 8'hC0, 8'hE0};
    step(3'b001, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(3'b011, 8'hFF, 1'b1, 1'b1);
      n_checks++;
      if (q !== exp_q[k]) $display("FAIL shr_q[%0d]: got %h want %h", k, q, exp_q[k]); else n_pass++;
    end
    n_checks++;
    if (shift_cnt !== 4'd3) $display("FAIL shr_cnt: got %0d want 3", shift_cnt); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL shr_done: got %b want 0", done); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step(3'b111, 8'h5A, 1'b0, 1'b1);
      n_checks++;
      if (q !== 8'hE0) $display("FAIL rsvd_q[%0d]: got %h want e0", k, q); else n_pass++;
      n_checks++;
      if (shift_cnt !== 4'd3) $display("FAIL rsvd_cnt[%0d]: got %0d want 3", k, shift_cnt); else n_pass++;
    end
    step(3'b000, 8'h11, 1'b1, 1'b1);
    n_checks++;
    if ({q, shift_cnt} !== {8'hE0, 4'd3}) $display("FAIL hold_state: got %h/%0d want e0/3", q, shift_cnt); else n_pass++;
  endtask

  task automatic test_clear();
    step(3'b001, 8'h81, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(3'b100, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({q, shift_cnt} !== {8'h30, 4'd5}) $display("FAIL rol5_state: got %h/%0d want 30/5", q, shift_cnt); else n_pass++;
    step(3'b110, 8'hFF, 1'b1, 1'b1);
    n_checks++;
    if (q !== 8'h00) $display("FAIL clear_q: got %h want 00", q); else n_pass++;
    n_checks++;
    if (shift_cnt !== 4'd0) $display("FAIL clear_cnt: got %0d want 0", shift_cnt); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL clear_done: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    step(3'b001, 8'h0F, 1'b0, 1'b0);
    step(3'b010, 8'h00, 1'b0, 1'b1);
    step(3'b010, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if ({q, shift_cnt} !== {8'h3F, 4'd2}) $display("FAIL pre_reset_state: got %h/%0d want 3f/2", q, shift_cnt); else n_pass++;
    sin_r = 1'b0;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (q !== 8'hA5) $display("FAIL midreset_q: got %h want a5", q); else n_pass++;
    n_checks++;
    if ({shift_cnt, done} !== {4'd0, 1'b0}) $display("FAIL midreset_cnt: got %0d/%b want 0/0", shift_cnt, done); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b010, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'h4A) $display("FAIL post_release_q: got %h want 4a", q); else n_pass++;
    n_checks++;
    if (shift_cnt !== 4'd1) $display("FAIL post_release_cnt: got %0d want 1", shift_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0] md;
    logic [7:0] dv;
    logic       sl;
    logic       sr;
    for (int k = 0; k < 200; k++) begin
      md = 3'($urandom_range(0, 7));
      dv = 8'($urandom);
      sl = 1'($urandom);
      sr = 1'($urandom);
      step(md, dv, sl, sr);
      n_checks++;
      if (q !== 8'(m_q)) $display("FAIL rand_q[%0d]: got %h want %h (mode %0d)", k, q, 8'(m_q), md); else n_pass++;
      n_checks++;
      if (shift_cnt !== 4'(m_cnt)) $display("FAIL rand_cnt[%0d]: got %0d want %0d", k, shift_cnt, m_cnt); else n_pass++;
      n_checks++;
      if (done !== (m_cnt == W)) $display("FAIL rand_done[%0d]: got %b want %b", k, done, (m_cnt == W)); else n_pass++;
      n_checks++;
      if ({sout_l, sout_r} !== {1'(m_q / (MODV / 2)), 1'(m_q % 2)})
        $display("FAIL rand_sout[%0d]: got %b%b want %0d%0d", k, sout_l, sout_r, m_q / (MODV / 2), m_q % 2);
      else n_pass++;
    end
  endtask

  initial begin
    m_q = 0;
    m_cnt = 0;
    test_reset();
    test_shl();
    test_ror();
    test_shr_hold();
    test_clear();
    test_reset_mid_shift();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
